// File: rtl/pc_control_pkg.sv
// pc_control_pkg
// Shared types and constants for the program-counter unit.
//   pc_state_e      : fetch-side control state (run / flush bubble / halted).
//   pc_redirect_e   : which flow-change source wins in the run state.
//   decode_redirect : fixed-priority resolution of the flow-change inputs.
package pc_control_pkg;

   // 2-bit state encoding; flush and halted outputs are decoded from it.
   typedef enum logic [1:0] {
      PcRun    = 2'd0,
      PcFlush  = 2'd1,
      PcHalted = 2'd2
   } pc_state_e;

   // Default handler address for SIIC; the top module exposes it as a parameter.
   localparam logic [15:0] SiicVectorDefault = 16'h0002;

   // Instruction size in bytes; sequential flow and link address use pc + 2.
   localparam int unsigned PcStepBytes = 2;

   typedef enum logic [2:0] {
      RdNone    = 3'd0,
      RdHalt    = 3'd1,
      RdSiic    = 3'd2,
      RdRti     = 3'd3,
      RdBranch  = 3'd4,
      RdJumpReg = 3'd5
   } pc_redirect_e;

   // Priority: halt > siic > rti > taken branch/jump > sequential.
   // jump_reg only matters when the branch block reports taken.
   function automatic pc_redirect_e decode_redirect(input logic halt,
                                                    input logic siic,
                                                    input logic rti,
                                                    input logic brch_taken,
                                                    input logic jump_reg);
      pc_redirect_e rd;
      rd = RdNone;
      if (halt) begin
         rd = RdHalt;
      end else if (siic) begin
         rd = RdSiic;
      end else if (rti) begin
         rd = RdRti;
      end else if (brch_taken) begin
         rd = jump_reg ? RdJumpReg : RdBranch;
      end
      return rd;
   endfunction

endpackage

// File: rtl/pc_target_adder.sv
// pc_target_adder
// WIDTH-bit wrap-around adder used for every address computation in the PC unit.
// The carry out is dropped so all sums are modulo 2^WIDTH.
//   a_i   : first operand
//   b_i   : second operand
//   sum_o : (a_i + b_i) mod 2^WIDTH
module pc_target_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_control.sv
// pc_control
// Program-counter unit downstream of the branch-condition logic. Holds the
// architectural PC and EPC, computes the next fetch address for sequential,
// branch, jump-register, SIIC and RTI flow, raises a one-cycle flush after each
// redirect and owns the fetch-side HALT state.
//   clk           : clock, all state updates on the rising edge
//   rst           : synchronous active-high reset, overrides every other input
//   stall_i       : hold pc, epc and state this cycle
//   brch_taken_i  : taken decision (conditional branch true, or jump)
//   jump_reg_i    : target is register-relative; qualifies brch_taken_i
//   imm_offset_i  : sign-extended displacement
//   reg_target_i  : Rs value for register-relative jumps
//   halt_i        : HALT decoded
//   siic_i        : SIIC decoded
//   rti_i         : RTI decoded
//   pc_o          : current fetch address
//   pc_plus2_o    : pc_o + 2, combinational
//   epc_o         : saved exception return address
//   flush_o       : squash the instruction currently in decode
//   halted_o      : processor halted, fetch frozen
module pc_control
   import pc_control_pkg::*;
#(
   parameter int unsigned       WIDTH       = 16,
   parameter logic [WIDTH-1:0]  RESET_PC    = '0,
   parameter logic [WIDTH-1:0]  SIIC_VECTOR = WIDTH'(SiicVectorDefault)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             brch_taken_i,
   input  logic             jump_reg_i,
   input  logic [WIDTH-1:0] imm_offset_i,
   input  logic [WIDTH-1:0] reg_target_i,
   input  logic             halt_i,
   input  logic             siic_i,
   input  logic             rti_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus2_o,
   output logic [WIDTH-1:0] epc_o,
   output logic             flush_o,
   output logic             halted_o
);

   localparam logic [WIDTH-1:0] PcStep = WIDTH'(PcStepBytes);

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;

   logic [WIDTH-1:0] pc_plus2;
   logic [WIDTH-1:0] brch_target;
   logic [WIDTH-1:0] jreg_target;
   pc_redirect_e     redirect;

   // Sequential / link address.
   pc_target_adder #(
      .WIDTH (WIDTH)
   ) u_add_seq (
      .a_i   (pc_q),
      .b_i   (PcStep),
      .sum_o (pc_plus2)
   );

   // PC-relative branch target, relative to the following instruction.
   pc_target_adder #(
      .WIDTH (WIDTH)
   ) u_add_brch (
      .a_i   (pc_plus2),
      .b_i   (imm_offset_i),
      .sum_o (brch_target)
   );

   // Register-relative jump target.
   pc_target_adder #(
      .WIDTH (WIDTH)
   ) u_add_jreg (
      .a_i   (reg_target_i),
      .b_i   (imm_offset_i),
      .sum_o (jreg_target)
   );

   assign redirect = decode_redirect(halt_i, siic_i, rti_i, brch_taken_i, jump_reg_i);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;

      if (!stall_i) begin
         case (state_q)
            PcRun: begin
               // Any redirect goes through PcFlush, even when the target happens
               // to equal pc + 2, so decode is always squashed after a redirect.
               case (redirect)
                  RdHalt: begin
                     state_d = PcHalted;
                  end
                  RdSiic: begin
                     epc_d   = pc_plus2;
                     pc_d    = SIIC_VECTOR;
                     state_d = PcFlush;
                  end
                  RdRti: begin
                     pc_d    = epc_q;
                     state_d = PcFlush;
                  end
                  RdBranch: begin
                     pc_d    = brch_target;
                     state_d = PcFlush;
                  end
                  RdJumpReg: begin
                     pc_d    = jreg_target;
                     state_d = PcFlush;
                  end
                  default: begin
                     pc_d = pc_plus2;
                  end
               endcase
            end
            PcFlush: begin
               // Control inputs here belong to the squashed wrong-path instruction.
               pc_d    = pc_plus2;
               state_d = PcRun;
            end
            PcHalted: begin
               // Frozen until reset.
            end
            default: begin
               state_d = PcRun;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PcRun;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus2_o = pc_plus2;
   assign epc_o      = epc_q;
   assign flush_o    = (state_q == PcFlush);
   assign halted_o   = (state_q == PcHalted);

endmodule
